// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit field width,
// the all-dark cathode pattern and the hex font table.
package seg_pkg;

    localparam int unsigned DIGIT_W = 4;

    // Cathodes are active low, so all ones turns every segment off.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex font, active low, bit order {g,f,e,d,c,b,a}; entry 0 is the LSB slice.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/seg_font_decode.sv
// Combinational hex-to-seven-segment decoder (active-low cathodes).
module seg_font_decode
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_val,
    output logic [6:0]         o_seg
);

    // Straight table lookup into the shared font.
    always_comb begin
        o_seg = SEG_FONT[i_val];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with a shadow/active buffer
// pair committed at frame boundaries and a per-slot anode dead time.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLANK_CYC  = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]         i_dp_in,
    input  logic [NUM_DIGITS-1:0]         i_blank_in,
    input  logic                          i_load,
    output logic [6:0]                    o_seg,
    output logic                          o_dp,
    output logic [NUM_DIGITS-1:0]         o_an,
    output logic                          o_frame_done
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned BUF_W = DIGIT_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;

    // Shadow (written by load) and active (displayed) buffers
    logic [BUF_W-1:0]      r_sh_digits;
    logic [NUM_DIGITS-1:0] r_sh_dp;
    logic [NUM_DIGITS-1:0] r_sh_blank;
    logic [BUF_W-1:0]      r_act_digits;
    logic [NUM_DIGITS-1:0] r_act_dp;
    logic [NUM_DIGITS-1:0] r_act_blank;

    // Registered outputs
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    logic                  w_cnt_tc;
    logic                  w_idx_last;
    logic                  w_wrap;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [IDX_W-1:0]      w_idx_next;
    logic [NUM_DIGITS-1:0] w_commit_blank;
    logic [DIGIT_W-1:0]    w_cur_digit;
    logic                  w_cur_dp;
    logic                  w_cur_blank;
    logic [NUM_DIGITS-1:0] w_an_sel;
    logic [6:0]            w_font;
    logic                  w_in_gap;
    logic                  w_dark;
    logic [6:0]            w_seg_d;
    logic                  w_dp_d;
    logic [NUM_DIGITS-1:0] w_an_d;
`ifdef SEG_SCAN_LZB_EN
    logic                  w_suppress;
`endif

    // Divider and digit index next state; >= comparisons pull any
    // out-of-range value back to 0 at the next terminal count.
    always_comb begin
        w_cnt_tc   = (r_cnt >= CNT_MAX);
        w_idx_last = (r_idx >= IDX_MAX);
        w_wrap     = w_cnt_tc && w_idx_last;
        w_cnt_next = w_cnt_tc ? '0 : r_cnt + 1'b1;
        w_idx_next = r_idx;
        if (w_cnt_tc) begin
            w_idx_next = w_idx_last ? '0 : r_idx + 1'b1;
        end
    end

    // Blank mask captured into the active buffer at commit.
    always_comb begin
        w_commit_blank = r_sh_blank;
`ifdef SEG_SCAN_LZB_EN
        // Walk from the most significant digit down; suppression ends at the
        // first shown non-zero digit or at any digit carrying a decimal point.
        w_suppress = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (r_sh_dp[k]) begin
                w_suppress = 1'b0;
            end
            if (w_suppress && (r_sh_digits[k*DIGIT_W +: DIGIT_W] == '0)) begin
                w_commit_blank[k] = 1'b1;
            end else if (!r_sh_blank[k] && (r_sh_digits[k*DIGIT_W +: DIGIT_W] != '0)) begin
                w_suppress = 1'b0;
            end
        end
`endif
    end

    // Select the active-buffer fields for the digit currently being scanned.
    always_comb begin
        w_cur_digit = '0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b1;
        w_an_sel    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_cur_digit = r_act_digits[k*DIGIT_W +: DIGIT_W];
                w_cur_dp    = r_act_dp[k];
                w_cur_blank = r_act_blank[k];
                w_an_sel[k] = 1'b0;
            end
        end
    end

    seg_font_decode u_font (
        .i_val (w_cur_digit),
        .o_seg (w_font)
    );

    // Output next state: dead time forces everything off, blanked digits keep the anode.
    always_comb begin
        w_in_gap = (r_cnt < BLANK_LIM);
        w_dark   = w_in_gap || w_cur_blank;
        w_an_d   = w_in_gap ? '1 : w_an_sel;
        w_seg_d  = w_dark ? SEG_OFF : w_font;
        w_dp_d   = w_dark ? 1'b1 : ~w_cur_dp;
    end

    // Scan counter and digit index registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_idx <= w_idx_next;
        end
    end

    // Shadow capture on load; commit to active on the index wrap using the
    // pre-load shadow contents when both happen on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_digits  <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= '0;
            r_act_digits <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
        end else begin
            if (i_load) begin
                r_sh_digits <= i_digits;
                r_sh_dp     <= i_dp_in;
                r_sh_blank  <= i_blank_in;
            end
            if (w_wrap) begin
                r_act_digits <= r_sh_digits;
                r_act_dp     <= r_sh_dp;
                r_act_blank  <= w_commit_blank;
            end
        end
    end

    // Output registers, one cycle behind the scan state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_d;
            r_dp         <= w_dp_d;
            r_an         <= w_an_d;
            r_frame_done <= w_wrap;
        end
    end

    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_an         = r_an;
    assign o_frame_done = r_frame_done;

endmodule
